// File: rtl/crc_serial_codec.sv
// Parametrised serial CRC encoder with a valid/ready bit input and a held, back-pressured codeword output.
// Optional codeword check mode is enabled by defining CRC_CHECK_EN.
module crc_serial_codec #(
  parameter int              MSG_W = 5,
  parameter int              CRC_W = 3,
  parameter logic [CRC_W-1:0] POLY = 3'b011,
  parameter logic [CRC_W-1:0] INIT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic                   clear,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSG_W+CRC_W-1:0] out_data,
  output logic                   crc_ok
);

  localparam int CNT_W = $clog2(MSG_W + CRC_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [CRC_W-1:0] crc, crc_next;
  logic [MSG_W-1:0] msg, msg_next;
  logic [CNT_W-1:0] count;
  logic             fb, accept, out_hs, last, mode_f;

  assign fb       = in_bit ^ crc[CRC_W-1];
  assign crc_next = (crc << 1) ^ (fb ? POLY : '0);
  assign msg_next = (msg << 1) | MSG_W'(in_bit);
  assign accept   = ena & in_valid & (state != DONE);
  assign out_hs   = ena & out_valid & out_ready;

`ifdef CRC_CHECK_EN
  logic mode_q;
  // mode is live only on the frame's first bit; afterwards the latched copy rules
  assign mode_f = (state == IDLE) ? mode : mode_q;
  assign last   = mode_f ? (count == CNT_W'(MSG_W + CRC_W - 1))
                         : (count == CNT_W'(MSG_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mode_q <= 1'b0;
    else if (ena && !clear && accept && state == IDLE)
      mode_q <= mode;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_f      = 1'b0;
  assign last        = (count == CNT_W'(MSG_W - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (ena)
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_next = last ? DONE : SHIFT;
        SHIFT:   if (accept && last) state_next = DONE;
        DONE:    if (out_hs) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc       <= INIT;
      msg       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      crc_ok    <= 1'b0;
    end else if (ena) begin
      if (clear || out_hs) begin
        crc       <= INIT;
        msg       <= '0;
        count     <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        crc_ok    <= 1'b0;
      end else if (accept) begin
        crc   <= crc_next;
        count <= count + CNT_W'(1);
        if (!mode_f)
          msg <= msg_next;
        // final bit: register the codeword from the next-state values directly
        if (last) begin
          out_valid <= 1'b1;
          out_data  <= mode_f ? {{MSG_W{1'b0}}, crc_next} : {msg_next, crc_next};
          crc_ok    <= mode_f & (crc_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_serial_codec.sv
// Directed self-checking bench for crc_serial_codec: default CRC-3 instance plus a CRC-8 instance.
module tb_crc_serial_codec;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena, clear, mode, in_valid, in_bit, out_ready;
  logic       in_ready, out_valid, crc_ok;
  logic [7:0] out_data;

  logic        b_ena, b_clear, b_mode, b_in_valid, b_in_bit, b_out_ready;
  logic        b_in_ready, b_out_valid, b_crc_ok;
  logic [15:0] b_out_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc_serial_codec dut (
    .clk(clk), .reset(reset), .ena(ena), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .crc_ok(crc_ok)
  );

  crc_serial_codec #(.MSG_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00)) dut8 (
    .clk(clk), .reset(reset), .ena(b_ena), .clear(b_clear), .mode(b_mode),
    .in_valid(b_in_valid), .in_bit(b_in_bit), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .crc_ok(b_crc_ok)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || crc_ok !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%h ok=%b ready=%b, required 0 00 0 1",
               out_valid, out_data, crc_ok, in_ready);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_encode();
    send_bits(16'b1000, 4);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL enc_early_valid: got %b, required 0", out_valid);
    end
    send_bits(16'b0, 1);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81 || crc_ok !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL enc_10000: valid=%b data=%h ok=%b ready=%b, required 1 81 0 0",
               out_valid, out_data, crc_ok, in_ready);
    end
    drain();
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL enc_handshake: valid=%b data=%h ready=%b, required 0 00 1",
               out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_bits(16'b11111, 5);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 8'hFE || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, required 1 fe 0",
                 c, out_valid, out_data, in_ready);
      end
    end
    // the bit offered on the handshake cycle must be ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
    send_bits(16'b10000, 5);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++;
      $display("FAIL b2b_frame: valid=%b data=%h, required 1 81", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_clear();
    send_bits(16'b10, 2);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL clear_state: valid=%b ready=%b data=%h, required 0 1 00",
               out_valid, in_ready, out_data);
    end
    send_bits(16'b10000, 5);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++;
      $display("FAIL clear_refill: valid=%b data=%h, required 1 81", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_async_reset();
    send_bits(16'b11, 2);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    send_bits(16'b10000, 5);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++;
      $display("FAIL reset_mid_shift: valid=%b data=%h, required 1 81", out_valid, out_data);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async_done: valid=%b data=%h ready=%b, required 0 00 1",
               out_valid, out_data, in_ready);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ena();
    send_bits(16'b10, 2);
    ena = 1'b0;
    send_bits(16'b111, 3);
    ena = 1'b1;
    send_bits(16'b000, 3);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++;
      $display("FAIL ena_gap_frame: valid=%b data=%h, required 1 81", out_valid, out_data);
    end
    ena       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      n_err++;
      $display("FAIL ena_hold_done: valid=%b data=%h, required 1 81", out_valid, out_data);
    end
    ena = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL ena_resume_hs: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_mode();
`ifdef CRC_CHECK_EN
    mode = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1;
    tick();
    mode = 1'b0;
    send_bits(16'b0000001, 7);
    n_vec++;
    if (out_valid !== 1'b1 || crc_ok !== 1'b1 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL check_good: valid=%b ok=%b data=%h, required 1 1 00",
               out_valid, crc_ok, out_data);
    end
    drain();
    mode = 1'b1;
    send_bits(16'b10010001, 8);
    mode = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || crc_ok !== 1'b0 || out_data !== 8'h01) begin
      n_err++;
      $display("FAIL check_bad: valid=%b ok=%b data=%h, required 1 0 01",
               out_valid, crc_ok, out_data);
    end
    drain();
`else
    mode = 1'b1;
    send_bits(16'b10000, 5);
    mode = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 8'h81 || crc_ok !== 1'b0) begin
      n_err++;
      $display("FAIL mode_ignored: valid=%b data=%h ok=%b, required 1 81 0",
               out_valid, out_data, crc_ok);
    end
    drain();
`endif
  endtask

  task automatic test_crc8();
    logic [7:0] byte_v;
    byte_v = 8'h31;
    for (int i = 7; i >= 0; i--) begin
      b_in_valid = 1'b1;
      b_in_bit   = byte_v[i];
      tick();
    end
    b_in_valid = 1'b0;
    n_vec++;
    if (b_out_valid !== 1'b1 || b_out_data !== 16'h3197 || b_crc_ok !== 1'b0) begin
      n_err++;
      $display("FAIL crc8_0x31: valid=%b data=%h ok=%b, required 1 3197 0",
               b_out_valid, b_out_data, b_crc_ok);
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    n_vec++;
    if (b_out_valid !== 1'b0 || b_out_data !== 16'h0000 || b_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL crc8_handshake: valid=%b data=%h ready=%b, required 0 0000 1",
               b_out_valid, b_out_data, b_in_ready);
    end
  endtask

  initial begin
    reset = 1'b0; ena = 1'b1; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    b_ena = 1'b1; b_clear = 1'b0; b_mode = 1'b0;
    b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b0;
    #1;
    test_reset();
    test_encode();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_ena();
    test_mode();
    test_crc8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
